// File: rtl/regfile_pkg.sv
// Shared register-file constants and types.
package regfile_pkg;
  localparam int REG_WIDTH  = 32;
  localparam int REG_ADDR_W = 5;
  localparam int REG_COUNT  = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [REG_WIDTH-1:0]  reg_data_t;
endpackage

// File: rtl/decoder_5to32.sv
// 5-to-32 one-hot decoder; all outputs low when not enabled.
import regfile_pkg::*;

module decoder_5to32 (
  input  logic                 i_en,
  input  reg_addr_t            i_addr,
  output logic [REG_COUNT-1:0] o_row
);

  // Drive the single row selected by the address.
  always_comb begin
    o_row = '0;
    if (i_en) o_row[i_addr] = 1'b1;
  end

endmodule

// File: rtl/regfile_32x32.sv
// 32x32 register file with a one-entry write staging register.
// Entry 0 reads as zero and has no storage.
// Optional macro REGFILE_BYPASS_EN: forward the staged write to the read
// ports and tie hazard low; otherwise reads see the array only and hazard
// flags a read of a staged-but-uncommitted address.
import regfile_pkg::*;

module regfile_32x32 #(
  parameter int WIDTH      = 32,
  parameter int DEPTH_LOG2 = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DEPTH_LOG2-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic [DEPTH_LOG2-1:0] rd_addr_a,
  input  logic [DEPTH_LOG2-1:0] rd_addr_b,
  output logic [WIDTH-1:0]      rd_data_a,
  output logic [WIDTH-1:0]      rd_data_b,
  output logic                  hazard
);

  logic                  r_stg_vld;
  logic [DEPTH_LOG2-1:0] r_stg_addr;
  logic [WIDTH-1:0]      r_stg_data;

  logic [REG_COUNT-1:0]            w_row_en;
  logic [REG_COUNT-1:0][WIDTH-1:0] w_mem;
  logic                            w_unused_row0;

  // Capture the write request; address-0 writes never become valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stg_vld  <= 1'b0;
      r_stg_addr <= '0;
      r_stg_data <= '0;
    end else begin
      r_stg_vld <= wr_en && (wr_addr != REG_ZERO);
      if (wr_en) begin
        r_stg_addr <= wr_addr;
        r_stg_data <= wr_data;
      end
    end
  end

  decoder_5to32 u_dec (
    .i_en   (r_stg_vld),
    .i_addr (r_stg_addr),
    .o_row  (w_row_en)
  );

  // Row 0 is never written; its enable is intentionally dropped.
  assign w_unused_row0 = w_row_en[0];
  assign w_mem[0]      = '0;

  for (genvar g = 1; g < REG_COUNT; g++) begin : g_row
    logic [WIDTH-1:0] r_row;

    // Commit the staged data into this row when it is selected.
    always_ff @(posedge clk) begin
      if (!rst_n)           r_row <= '0;
      else if (w_row_en[g]) r_row <= r_stg_data;
    end

    assign w_mem[g] = r_row;
  end

`ifdef REGFILE_BYPASS_EN
  // Staged write is forwarded, so no read ever observes stale data.
  assign rd_data_a = (r_stg_vld && (rd_addr_a == r_stg_addr)) ? r_stg_data : w_mem[rd_addr_a];
  assign rd_data_b = (r_stg_vld && (rd_addr_b == r_stg_addr)) ? r_stg_data : w_mem[rd_addr_b];
  assign hazard    = 1'b0;
`else
  // Reads see the array only; upstream must stall while hazard is high.
  assign rd_data_a = w_mem[rd_addr_a];
  assign rd_data_b = w_mem[rd_addr_b];
  assign hazard    = r_stg_vld && ((rd_addr_a == r_stg_addr) || (rd_addr_b == r_stg_addr));
`endif

endmodule
